// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared widths and CDB entry type for the completion arbiter
// Purpose: common constants and the broadcast entry record used by the FIFOs and arbiter.
// Ports: none (package).
package cdb_arbiter_pkg;

  localparam int TAG_W     = 6;
  localparam int ROB_IDX_W = 6;
  localparam int XLEN      = 32;
  localparam int CDB_PORTS = 2;

  typedef struct packed {
    logic [XLEN-1:0]      data;
    logic [TAG_W-1:0]     tag;
    logic [ROB_IDX_W-1:0] rob_index;
    logic                 loadstore;
  } cdb_entry_t;

endpackage

// File: rtl/completion_fifo.sv
// rtl/completion_fifo.sv - per-source completion buffer feeding the CDB arbiter
// Purpose: DEPTH-entry FIFO of cdb_entry_t with registered count.
// Ports: clk, rst (sync, active-high); push/push_entry write side;
//        pop/head read side; count, full, empty status from registered state.
module completion_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  cdb_entry_t              push_entry,
  input  logic                    pop,
  output cdb_entry_t              head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);

  cdb_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Guarded locally as well so a misbehaving caller cannot corrupt the pointers.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers are exactly PTR_W bits, so DEPTH being a power of two makes them wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_do_push) r_mem[r_wr_ptr] <= push_entry;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-slot common data bus arbiter over FU and load completion FIFOs
// Purpose: buffers completions per source and round-robin grants up to two per cycle onto the CDB.
// Ports: clk, rst (sync, active-high); fu_* [NUM_FU] FU results; load_* LSU completion;
//        src_ready [NUM_FU+1] per-source push acceptance; cdb_* [2] registered broadcast slots;
//        overflow sticky drop indicator.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NUM_FU = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      fu_data      [NUM_FU],
  input  logic [TAG_W-1:0]     fu_tags      [NUM_FU],
  input  logic [ROB_IDX_W-1:0] fu_rob_index [NUM_FU],
  input  logic                 fu_loadstore [NUM_FU],
  input  logic                 fu_valid     [NUM_FU],
  input  logic [XLEN-1:0]      load_data,
  input  logic [TAG_W-1:0]     load_tag,
  input  logic [ROB_IDX_W-1:0] load_rob_index,
  input  logic                 load_valid,
  output logic                 src_ready     [NUM_FU+1],
  output logic [XLEN-1:0]      cdb_data      [CDB_PORTS],
  output logic [TAG_W-1:0]     cdb_tags      [CDB_PORTS],
  output logic [ROB_IDX_W-1:0] cdb_rob_index [CDB_PORTS],
  output logic                 cdb_loadstore [CDB_PORTS],
  output logic                 cdb_valid     [CDB_PORTS],
  output logic                 overflow
);

  localparam int NSRC  = NUM_FU + 1;
  localparam int PTR_W = $clog2(NSRC);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  cdb_entry_t       w_in_entry [NSRC];
  cdb_entry_t       w_head     [NSRC];
  logic [CNT_W-1:0] w_count    [NSRC];
  logic [NSRC-1:0]  w_in_valid;
  logic [NSRC-1:0]  w_ready;
  logic [NSRC-1:0]  w_push;
  logic [NSRC-1:0]  w_pop;
  logic [NSRC-1:0]  w_full;
  logic [NSRC-1:0]  w_empty;

  logic [PTR_W-1:0]     r_rr_ptr;
  logic                 r_overflow;
  cdb_entry_t           r_cdb       [CDB_PORTS];
  logic [CDB_PORTS-1:0] r_cdb_valid;

  logic [CDB_PORTS-1:0] w_slot_vld;
  logic [PTR_W-1:0]     w_slot_src [CDB_PORTS];
  logic [PTR_W-1:0]     w_last_idx;
  logic [PTR_W:0]       w_scan_sum;
  logic [PTR_W-1:0]     w_scan_idx;
  logic [PTR_W:0]       w_rr_inc;
  logic [PTR_W-1:0]     w_rr_next;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    if (s < NUM_FU) begin : g_fu
      assign w_in_entry[s] = {fu_data[s], fu_tags[s], fu_rob_index[s], fu_loadstore[s]};
      assign w_in_valid[s] = fu_valid[s];
    end else begin : g_ld
      // Loads always complete with a register value, never an LSQ address.
      assign w_in_entry[s] = {load_data, load_tag, load_rob_index, 1'b0};
      assign w_in_valid[s] = load_valid;
    end

    assign w_ready[s]   = (w_count[s] < CNT_W'(DEPTH));
    assign src_ready[s] = w_ready[s];
    assign w_push[s]    = w_in_valid[s] && w_ready[s];

    completion_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (w_push[s]),
      .push_entry (w_in_entry[s]),
      .pop        (w_pop[s]),
      .head       (w_head[s]),
      .count      (w_count[s]),
      .full       (w_full[s]),
      .empty      (w_empty[s])
    );
  end

  // Round-robin scan from r_rr_ptr. Every index is visited once, so a FIFO holding
  // several entries still gets at most one grant per cycle.
  always_comb begin
    w_pop      = '0;
    w_slot_vld = '0;
    w_last_idx = r_rr_ptr;
    w_scan_sum = '0;
    w_scan_idx = '0;
    for (int j = 0; j < CDB_PORTS; j++) w_slot_src[j] = '0;
    for (int k = 0; k < NSRC; k++) begin
      w_scan_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_scan_sum >= (PTR_W+1)'(NSRC)) w_scan_sum = w_scan_sum - (PTR_W+1)'(NSRC);
      w_scan_idx = w_scan_sum[PTR_W-1:0];
      if (!w_empty[w_scan_idx] && !w_slot_vld[1]) begin
        if (!w_slot_vld[0]) begin
          w_slot_vld[0] = 1'b1;
          w_slot_src[0] = w_scan_idx;
        end else begin
          w_slot_vld[1] = 1'b1;
          w_slot_src[1] = w_scan_idx;
        end
        w_pop[w_scan_idx] = 1'b1;
        w_last_idx        = w_scan_idx;
      end
    end
    w_rr_inc  = {1'b0, w_last_idx} + 1'b1;
    w_rr_next = (w_rr_inc == (PTR_W+1)'(NSRC)) ? '0 : w_rr_inc[PTR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_cdb_valid <= '0;
      for (int j = 0; j < CDB_PORTS; j++) r_cdb[j] <= '0;
    end else begin
      if (|w_slot_vld) r_rr_ptr <= w_rr_next;
      if (|(w_in_valid & w_full)) r_overflow <= 1'b1;
      for (int j = 0; j < CDB_PORTS; j++) begin
        r_cdb_valid[j] <= w_slot_vld[j];
        r_cdb[j]       <= w_slot_vld[j] ? w_head[w_slot_src[j]] : '0;
      end
    end
  end

  for (genvar j = 0; j < CDB_PORTS; j++) begin : g_out
    assign cdb_data[j]      = r_cdb[j].data;
    assign cdb_tags[j]      = r_cdb[j].tag;
    assign cdb_rob_index[j] = r_cdb[j].rob_index;
    assign cdb_loadstore[j] = r_cdb[j].loadstore;
    assign cdb_valid[j]     = r_cdb_valid[j];
  end

  assign overflow = r_overflow;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NUM_FU = 3;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fu_data      [NUM_FU];
  logic [5:0]  fu_tags      [NUM_FU];
  logic [5:0]  fu_rob_index [NUM_FU];
  logic        fu_loadstore [NUM_FU];
  logic        fu_valid     [NUM_FU];
  logic [31:0] load_data;
  logic [5:0]  load_tag;
  logic [5:0]  load_rob_index;
  logic        load_valid;
  logic        src_ready     [NUM_FU+1];
  logic [31:0] cdb_data      [2];
  logic [5:0]  cdb_tags      [2];
  logic [5:0]  cdb_rob_index [2];
  logic        cdb_loadstore [2];
  logic        cdb_valid     [2];
  logic        overflow;

  cdb_arbiter #(.DEPTH(DEPTH), .NUM_FU(NUM_FU)) dut (
    .clk(clk), .rst(rst),
    .fu_data(fu_data), .fu_tags(fu_tags), .fu_rob_index(fu_rob_index),
    .fu_loadstore(fu_loadstore), .fu_valid(fu_valid),
    .load_data(load_data), .load_tag(load_tag), .load_rob_index(load_rob_index),
    .load_valid(load_valid), .src_ready(src_ready),
    .cdb_data(cdb_data), .cdb_tags(cdb_tags), .cdb_rob_index(cdb_rob_index),
    .cdb_loadstore(cdb_loadstore), .cdb_valid(cdb_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_bcast = 0;
  bit mon_en  = 1'b0;

  // Expected entries per source, {data, tag, rob, loadstore}; source 3 is the load port.
  logic [44:0] q0[$], q1[$], q2[$], q3[$];
  logic [3:0]  rdy_tab [9];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input int s, input logic [44:0] e);
    case (s)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  function automatic int sb_size();
    return q0.size() + q1.size() + q2.size() + q3.size();
  endfunction

  task automatic sb_clear();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NUM_FU; i++) begin
      fu_valid[i] = 1'b0; fu_data[i] = '0; fu_tags[i] = '0;
      fu_rob_index[i] = '0; fu_loadstore[i] = 1'b0;
    end
    load_valid = 1'b0; load_data = '0; load_tag = '0; load_rob_index = '0;
  endtask

  task automatic drive_fu(input int i, input logic [31:0] d, input logic [5:0] t,
                          input logic [5:0] r, input logic ls, input bit acc);
    fu_data[i] = d; fu_tags[i] = t; fu_rob_index[i] = r; fu_loadstore[i] = ls;
    fu_valid[i] = 1'b1;
    if (acc) sb_push(i, {d, t, r, ls});
  endtask

  task automatic drive_load(input logic [31:0] d, input logic [5:0] t,
                            input logic [5:0] r, input bit acc);
    load_data = d; load_tag = t; load_rob_index = r; load_valid = 1'b1;
    if (acc) sb_push(3, {d, t, r, 1'b0});
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    sb_clear();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (sb_size() != 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (3) begin @(posedge clk); #1; end
    check(tag, sb_size(), 0);
  endtask

  // Every broadcast must be the oldest outstanding entry of some source.
  always @(negedge clk) begin
    logic [44:0] e;
    bit hit;
    if (mon_en) begin
      for (int j = 0; j < 2; j++) begin
        e = {cdb_data[j], cdb_tags[j], cdb_rob_index[j], cdb_loadstore[j]};
        if (cdb_valid[j]) begin
          hit = 1'b0;
          if (q0.size() > 0 && q0[0] == e) begin void'(q0.pop_front()); hit = 1'b1; end
          else if (q1.size() > 0 && q1[0] == e) begin void'(q1.pop_front()); hit = 1'b1; end
          else if (q2.size() > 0 && q2[0] == e) begin void'(q2.pop_front()); hit = 1'b1; end
          else if (q3.size() > 0 && q3[0] == e) begin void'(q3.pop_front()); hit = 1'b1; end
          n_bcast++;
          check($sformatf("sb_hit slot%0d data=%0h tag=%0d", j, cdb_data[j], cdb_tags[j]),
                64'(hit), 64'd1);
        end else begin
          check($sformatf("idle_zero slot%0d", j), 64'(e), 64'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    rdy_tab[0] = 4'hF; rdy_tab[1] = 4'hF; rdy_tab[2] = 4'hF; rdy_tab[3] = 4'hF;
    rdy_tab[4] = 4'hF; rdy_tab[5] = 4'hF; rdy_tab[6] = 4'h3; rdy_tab[7] = 4'hC;
    rdy_tab[8] = 4'h3;

    // Reset state
    do_reset();
    mon_en = 1'b1;
    check("rst_valid0", 64'(cdb_valid[0]), 0);
    check("rst_valid1", 64'(cdb_valid[1]), 0);
    check("rst_data0", 64'(cdb_data[0]), 0);
    check("rst_ovf", 64'(overflow), 0);
    check("rst_ready", 64'({src_ready[3], src_ready[2], src_ready[1], src_ready[0]}), 64'hF);

    // Single FU0 result, two-edge latency
    drive_fu(0, 32'h11, 6'd5, 6'd2, 1'b0, 1'b1);
    step();
    check("lat_min_valid0", 64'(cdb_valid[0]), 0);
    @(posedge clk); #1;
    check("single_valid0", 64'(cdb_valid[0]), 1);
    check("single_data0", 64'(cdb_data[0]), 64'h11);
    check("single_tag0", 64'(cdb_tags[0]), 5);
    check("single_rob0", 64'(cdb_rob_index[0]), 2);
    check("single_valid1", 64'(cdb_valid[1]), 0);
    drain("single_drain");

    // All four sources at once, round-robin from 0
    do_reset();
    for (int i = 0; i < NUM_FU; i++) drive_fu(i, 32'h100 + i, 6'(i + 1), 6'(i + 10), 1'b0, 1'b1);
    drive_load(32'h103, 6'd4, 6'd13, 1'b1);
    step();
    @(posedge clk); #1;
    check("rr_a_tag0", 64'(cdb_tags[0]), 1);
    check("rr_a_tag1", 64'(cdb_tags[1]), 2);
    @(posedge clk); #1;
    check("rr_b_tag0", 64'(cdb_tags[0]), 3);
    check("rr_b_tag1", 64'(cdb_tags[1]), 4);
    for (int i = 0; i < NUM_FU; i++) drive_fu(i, 32'h200 + i, 6'(i + 5), 6'(i + 20), 1'b0, 1'b1);
    drive_load(32'h203, 6'd8, 6'd23, 1'b1);
    step();
    @(posedge clk); #1;
    check("rr_wrap_tag0", 64'(cdb_tags[0]), 5);
    check("rr_wrap_tag1", 64'(cdb_tags[1]), 6);
    drain("rr_drain");

    // Loadstore flag: FU2 address result and a load together
    drive_fu(2, 32'h22, 6'd10, 6'd7, 1'b1, 1'b1);
    drive_load(32'h33, 6'd9, 6'd8, 1'b1);
    step();
    @(posedge clk); #1;
    check("ls_tag0", 64'(cdb_tags[0]), 10);
    check("ls_ls0", 64'(cdb_loadstore[0]), 1);
    check("ls_rob0", 64'(cdb_rob_index[0]), 7);
    check("ls_tag1", 64'(cdb_tags[1]), 9);
    check("ls_ls1", 64'(cdb_loadstore[1]), 0);
    drain("ls_drain");

    // Overload every source: FIFOs fill, pushes drop, overflow sticks
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      for (int s = 0; s < NUM_FU; s++)
        drive_fu(s, 32'h3000 + s * 256 + k, 6'(s * 16 + k), 6'(k), 1'b0, rdy_tab[k-1][s]);
      drive_load(32'h3300 + k, 6'(48 + k), 6'(k), rdy_tab[k-1][3]);
      step();
      check($sformatf("ovf_ready c%0d", k),
            64'({src_ready[3], src_ready[2], src_ready[1], src_ready[0]}), 64'(rdy_tab[k]));
      check($sformatf("ovf_flag c%0d", k), 64'(overflow), 64'(k >= 7));
    end
    drain("ovf_drain");
    check("ovf_sticky", 64'(overflow), 1);
    do_reset();
    check("ovf_cleared", 64'(overflow), 0);

    // Reset mid-operation discards buffered entries
    for (int k = 0; k < 3; k++) begin
      drive_fu(0, 32'h4400 + k, 6'(20 + k), 6'(k), 1'b0, 1'b1);
      step();
    end
    rst = 1'b1;
    @(posedge clk); #1;
    sb_clear();
    check("mid_rst_valid0", 64'(cdb_valid[0]), 0);
    check("mid_rst_valid1", 64'(cdb_valid[1]), 0);
    rst = 1'b0;
    b0 = n_bcast;
    @(posedge clk); #1;
    check("mid_rst_ready", 64'({src_ready[3], src_ready[2], src_ready[1], src_ready[0]}), 64'hF);
    repeat (6) begin @(posedge clk); #1; end
    check("mid_rst_stale", 64'(n_bcast - b0), 0);

    // Sustained FU0 stream: in order, pointer wrap, never backs up
    do_reset();
    b0 = n_bcast;
    for (int k = 0; k < 12; k++) begin
      drive_fu(0, 32'h5500 + k, 6'(k), 6'(k + 1), 1'b0, 1'b1);
      step();
      check($sformatf("stream_ready c%0d", k), 64'(src_ready[0]), 1);
      check($sformatf("stream_valid1 c%0d", k), 64'(cdb_valid[1]), 0);
    end
    drain("stream_drain");
    check("stream_count", 64'(n_bcast - b0), 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
